// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the IF stage: FSM encodings, NOP word, PC step and
// the word-alignment helper used on redirect targets.
package fetch_unit_pkg;

    // FSM encodings kept as plain constants for compatibility with older tools
    localparam logic [1:0] ST_FETCH = 2'd0;
    localparam logic [1:0] ST_HOLD  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] PC_STEP   = 32'd4;
    localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

    typedef logic [1:0] fetch_state_t;

    // Clear the byte-offset bits so every PC is word aligned
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & WORD_MASK;
    endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register: load a target, step by one word, or hold.
// Load has priority over increment; the increment wraps modulo 2^32.
module fetch_pc_reg
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        i_load,
    input  logic [31:0] i_load_val,
    input  logic        i_inc,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc_plus4
);

    logic [31:0] r_pc;

    assign o_pc       = r_pc;
    assign o_pc_plus4 = r_pc + PC_STEP;

    // PC update: redirect load wins over sequential step
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_pc <= align_word(RESET_PC);
        end else if (i_load) begin
            r_pc <= i_load_val;
        end else if (i_inc) begin
            r_pc <= o_pc_plus4;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// IF stage: owns the PC, fetches over a req/ack handshake with variable
// latency and drives the IF/ID register controls. Handles stalls, EX-stage
// redirects and memory wait states, inserting bubbles so ID never sees an
// instruction twice.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        ENABLE,
    input  logic        PC_write,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] INSTRUCTION,
    output logic [31:0] NEW_PC,
    output logic        IF_ID_write,
    output logic        IF_flush
);

    fetch_state_t r_state;
    fetch_state_t w_state_d;
    logic [31:0]  r_hold_instr;
    logic [31:0]  r_pend_target;

    logic         w_go;
    logic         w_redir;
    logic [31:0]  w_tgt;
    logic [31:0]  w_pc;
    logic [31:0]  w_pc_plus4;
    logic         w_pc_load;
    logic [31:0]  w_pc_load_val;
    logic         w_pc_inc;
    logic         w_hold_load;
    logic         w_pend_load;
    logic         w_req;
    logic         w_write;
    logic         w_flush;
    logic [31:0]  w_instr;

    // ENABLE=0 looks like a stall and also masks redirects
    assign w_go    = ENABLE & PC_write;
    assign w_redir = ENABLE & redirect_valid;
    assign w_tgt   = align_word(redirect_target);

    fetch_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .i_load     (w_pc_load),
        .i_load_val (w_pc_load_val),
        .i_inc      (w_pc_inc),
        .o_pc       (w_pc),
        .o_pc_plus4 (w_pc_plus4)
    );

    // Next-state, PC control and raw IF/ID controls from state and inputs
    always_comb begin
        w_state_d     = r_state;
        w_pc_load     = 1'b0;
        w_pc_load_val = w_tgt;
        w_pc_inc      = 1'b0;
        w_hold_load   = 1'b0;
        w_pend_load   = 1'b0;
        w_req         = 1'b0;
        w_write       = 1'b0;
        w_flush       = 1'b0;
        w_instr       = NOP_INSTR;

        case (r_state)
            ST_FETCH: begin
                w_req = 1'b1;
                if (w_redir) begin
                    w_flush = 1'b1;
                    if (imem_ack) begin
                        // Returned word belongs to the wrong path; drop it
                        w_pc_load = 1'b1;
                    end else begin
                        // Outstanding request must still complete first
                        w_pend_load = 1'b1;
                        w_state_d   = ST_DRAIN;
                    end
                end else if (imem_ack) begin
                    if (w_go) begin
                        w_instr  = imem_rdata;
                        w_write  = 1'b1;
                        w_pc_inc = 1'b1;
                    end else begin
                        w_hold_load = 1'b1;
                        w_state_d   = ST_HOLD;
                    end
                end else if (w_go) begin
                    w_flush = 1'b1;
                end
            end

            ST_HOLD: begin
                w_instr = r_hold_instr;
                if (w_redir) begin
                    w_pc_load = 1'b1;
                    w_flush   = 1'b1;
                    w_state_d = ST_FETCH;
                end else if (w_go) begin
                    w_write   = 1'b1;
                    w_pc_inc  = 1'b1;
                    w_state_d = ST_FETCH;
                end
            end

            ST_DRAIN: begin
                // Address stays at the stale PC until its ack arrives
                w_req   = 1'b1;
                w_flush = w_go | w_redir;
                if (w_redir) begin
                    w_pend_load = 1'b1;
                end
                if (imem_ack) begin
                    w_pc_load     = 1'b1;
                    w_pc_load_val = w_redir ? w_tgt : r_pend_target;
                    w_state_d     = ST_FETCH;
                end
            end

            default: begin
                w_state_d = ST_FETCH;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Captured word while stalled, and latest redirect target while draining
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_hold_instr  <= 32'h0;
            r_pend_target <= 32'h0;
        end else begin
            if (w_hold_load) begin
                r_hold_instr <= imem_rdata;
            end
            if (w_pend_load) begin
                r_pend_target <= w_tgt;
            end
        end
    end

    // Controls are forced low while reset is asserted
    assign imem_req    = w_req & RST_N;
    assign imem_addr   = w_pc;
    assign INSTRUCTION = w_instr;
    assign NEW_PC      = w_pc_plus4;
    assign IF_ID_write = w_write & RST_N;
    assign IF_flush    = w_flush & RST_N;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit. Memory returns ~addr on ack; every IF/ID write
// is matched against a scoreboard entry pushed when that cycle was driven.
module tb_fetch_unit;

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        ENABLE = 1'b1;
    logic        PC_write = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata;
    logic [31:0] INSTRUCTION;
    logic [31:0] NEW_PC;
    logic        IF_ID_write;
    logic        IF_flush;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] npc;
    } exp_t;

    exp_t sb_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    assign imem_rdata = imem_ack ? ~imem_addr : 32'hDEAD_BEEF;

    always #5 CLK = ~CLK;

    fetch_unit #(
        .RESET_PC (32'h0000_0000)
    ) dut (
        .CLK             (CLK),
        .RST_N           (RST_N),
        .ENABLE          (ENABLE),
        .PC_write        (PC_write),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .INSTRUCTION     (INSTRUCTION),
        .NEW_PC          (NEW_PC),
        .IF_ID_write     (IF_ID_write),
        .IF_flush        (IF_flush)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: got %h exp %h", tag, got, exp);
        end
    endtask

    // One clock: drive inputs, check controls at negedge, advance past posedge
    task automatic cyc(input logic en, input logic ack, input logic pcw, input logic rv,
                       input logic [31:0] tgt, input logic ereq, input logic [31:0] eaddr,
                       input logic ewr, input logic efl);
        ENABLE          = en;
        imem_ack        = ack;
        PC_write        = pcw;
        redirect_valid  = rv;
        redirect_target = tgt;
        if (ewr) sb_q.push_back('{instr: ~eaddr, npc: eaddr + 32'd4});
        @(negedge CLK);
        chk("imem_req", {31'b0, imem_req}, {31'b0, ereq});
        if (ereq) chk("imem_addr", imem_addr, eaddr);
        chk("IF_ID_write", {31'b0, IF_ID_write}, {31'b0, ewr});
        chk("IF_flush", {31'b0, IF_flush}, {31'b0, efl});
        @(posedge CLK);
        #1;
    endtask

    // Scoreboard pop on every IF/ID write; write and flush must be exclusive
    always @(negedge CLK) begin
        exp_t e;
        if (RST_N) begin
            chk("write_flush_excl", {31'b0, IF_ID_write & IF_flush}, 32'h0);
            if (IF_ID_write) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_write_instr", INSTRUCTION, 32'hXXXX_XXXX);
                end else begin
                    e = sb_q.pop_front();
                    chk("INSTRUCTION", INSTRUCTION, e.instr);
                    chk("NEW_PC", NEW_PC, e.npc);
                end
            end
        end
    end

    initial begin
        // Reset state
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_req", {31'b0, imem_req}, 32'h0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_write", {31'b0, IF_ID_write}, 32'h0);
        chk("rst_flush", {31'b0, IF_flush}, 32'h0);
        RST_N = 1'b1;

        // 1: same-cycle ack, one instruction per cycle
        cyc(H, H, H, L, 32'h0, H, 32'h0000_0000, H, L);
        cyc(H, H, H, L, 32'h0, H, 32'h0000_0004, H, L);
        cyc(H, H, H, L, 32'h0, H, 32'h0000_0008, H, L);
        cyc(H, H, H, L, 32'h0, H, 32'h0000_000C, H, L);

        // 2: three wait states on 0x10 -> bubbles, stable address
        cyc(H, L, H, L, 32'h0, H, 32'h0000_0010, L, H);
        cyc(H, L, H, L, 32'h0, H, 32'h0000_0010, L, H);
        cyc(H, L, H, L, 32'h0, H, 32'h0000_0010, L, H);
        cyc(H, H, H, L, 32'h0, H, 32'h0000_0010, H, L);

        // 3: stall while ack arrives at 0x14 -> HOLD, then written once
        cyc(H, H, L, L, 32'h0, H, 32'h0000_0014, L, L);
        cyc(H, L, L, L, 32'h0, L, 32'h0000_0014, L, L);
        cyc(H, L, H, L, 32'h0, L, 32'h0000_0014, H, L);
        cyc(H, H, H, L, 32'h0, H, 32'h0000_0018, H, L);

        // 4: redirects during wait on 0x1C; last target (0x43 -> 0x40) wins
        cyc(H, L, H, H, 32'h0000_0060, H, 32'h0000_001C, L, H);
        cyc(H, L, H, H, 32'h0000_0043, H, 32'h0000_001C, L, H);
        cyc(H, L, L, L, 32'h0, H, 32'h0000_001C, L, L);
        cyc(H, H, H, L, 32'h0, H, 32'h0000_001C, L, H);
        cyc(H, H, H, L, 32'h0, H, 32'h0000_0040, H, L);

        // ENABLE=0 ignores redirect and acts as stall
        cyc(L, L, H, H, 32'h0000_0200, H, 32'h0000_0044, L, L);

        // 5: redirect to 0x100 with stall while in HOLD; held word discarded
        cyc(H, H, L, L, 32'h0, H, 32'h0000_0044, L, L);
        cyc(H, L, L, H, 32'h0000_0100, L, 32'h0000_0044, L, H);
        cyc(H, H, H, L, 32'h0, H, 32'h0000_0100, H, L);

        // 6: wrap at top of address space
        cyc(H, H, H, H, 32'hFFFF_FFFC, H, 32'h0000_0104, L, H);
        cyc(H, H, H, L, 32'h0, H, 32'hFFFF_FFFC, H, L);
        cyc(H, H, H, L, 32'h0, H, 32'h0000_0000, H, L);
        cyc(H, L, H, L, 32'h0, H, 32'h0000_0004, L, H);

        // Reset mid-wait: controls drop immediately, restart at RESET_PC
        RST_N = 1'b0;
        #1;
        chk("midrst_req", {31'b0, imem_req}, 32'h0);
        chk("midrst_write", {31'b0, IF_ID_write}, 32'h0);
        chk("midrst_flush", {31'b0, IF_flush}, 32'h0);
        chk("midrst_addr", imem_addr, 32'h0);
        imem_ack = 1'b0;
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        cyc(H, H, H, L, 32'h0, H, 32'h0000_0000, H, L);

        chk("sb_empty", sb_q.size(), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
